// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - size encodings, FSM states and lane masks for the sub-word store controller
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [31:0] MASK_BYTE = 32'h0000_00FF;
  localparam logic [31:0] MASK_HALF = 32'h0000_FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  // Misaligned halves/words and the reserved size never reach memory.
  function automatic logic is_rejected(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_rejected = 1'b0;
      SZ_HALF: is_rejected = lo[0];
      SZ_WORD: is_rejected = (lo != 2'b00);
      default: is_rejected = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// rtl/store_lane_merge.sv - positions store data into its lane(s) and merges it into a read word
// Mem byte-enable output exists only when STORE_BYTE_EN_PORT_EN is defined.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic [31:0] rdata,
  output logic [31:0] shifted,
  output logic [31:0] mask,
`ifdef STORE_BYTE_EN_PORT_EN
  output logic [3:0]  be,
`endif
  output logic [31:0] merged
);

  always_comb begin
    shifted = data;
    mask    = 32'hFFFF_FFFF;
`ifdef STORE_BYTE_EN_PORT_EN
    be      = 4'b1111;
`endif
    case (size)
      SZ_BYTE: begin
        shifted = {24'h0, data[7:0]} << {addr, 3'b000};
        mask    = MASK_BYTE << {addr, 3'b000};
`ifdef STORE_BYTE_EN_PORT_EN
        be      = 4'b0001 << addr;
`endif
      end
      SZ_HALF: begin
        shifted = {16'h0, data[15:0]} << {addr[1], 4'b0000};
        mask    = MASK_HALF << {addr[1], 4'b0000};
`ifdef STORE_BYTE_EN_PORT_EN
        be      = 4'b0011 << {addr[1], 1'b0};
`endif
      end
      default: ;
    endcase
    merged = (rdata & ~mask) | (shifted & mask);
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// rtl/store_rmw_ctrl.sv - read-modify-write sequencer for SB/SH/SW into a RAM without byte enables
// Optional STORE_BYTE_EN_PORT_EN adds Mem_BE and writes sub-words directly.
module store_rmw_ctrl
  import store_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [31:0]       Req_Data,
  input  logic [1:0]        Req_Size,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_Rd,
  output logic              Mem_Wr,
  output logic [31:0]       Mem_WData,
  input  logic [31:0]       Mem_RData,
  input  logic              Mem_Ack,
`ifdef STORE_BYTE_EN_PORT_EN
  output logic [3:0]        Mem_BE,
`endif
  output logic              Done,
  output logic              Err
);

  localparam logic [15:0] WAIT_LIMIT = (ACK_TIMEOUT == 0) ? 16'd0 : 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lane;
  logic [31:0] lat_data;
  logic [31:0] lat_rdata;
  logic [15:0] wait_cnt;

  logic [1:0]  m_size;
  logic [1:0]  m_lane;
  logic [31:0] m_data;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] merged;
  logic        timed_out;
`ifdef STORE_BYTE_EN_PORT_EN
  logic [3:0]  be;
`endif

  // The lane datapath sees the live request while idle so the accept edge can use its result.
  assign m_size    = (state == IDLE) ? Req_Size      : lat_size;
  assign m_lane    = (state == IDLE) ? Req_Addr[1:0] : lat_lane;
  assign m_data    = (state == IDLE) ? Req_Data      : lat_data;
  assign timed_out = (ACK_TIMEOUT != 0) && (wait_cnt == WAIT_LIMIT);

  store_lane_merge u_merge (
    .size    (m_size),
    .addr    (m_lane),
    .data    (m_data),
    .rdata   (lat_rdata),
    .shifted (shifted),
    .mask    (mask),
`ifdef STORE_BYTE_EN_PORT_EN
    .be      (be),
`endif
    .merged  (merged)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      Req_Ready <= 1'b1;
      Mem_Addr  <= '0;
      Mem_Rd    <= 1'b0;
      Mem_Wr    <= 1'b0;
      Mem_WData <= '0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      lat_size  <= '0;
      lat_lane  <= '0;
      lat_data  <= '0;
      lat_rdata <= '0;
      wait_cnt  <= '0;
`ifdef STORE_BYTE_EN_PORT_EN
      Mem_BE    <= '0;
`endif
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Req_Valid) begin
            lat_size  <= Req_Size;
            lat_lane  <= Req_Addr[1:0];
            lat_data  <= Req_Data;
            Mem_Addr  <= {Req_Addr[ADDR_W-1:2], 2'b00};
            Req_Ready <= 1'b0;
            wait_cnt  <= '0;
            if (is_rejected(Req_Size, Req_Addr[1:0])) begin
              state <= ERR;
              Err   <= 1'b1;
`ifdef STORE_BYTE_EN_PORT_EN
            end else begin
              state     <= WR;
              Mem_Wr    <= 1'b1;
              Mem_WData <= shifted;
              Mem_BE    <= be;
            end
`else
            end else if (mask != 32'hFFFF_FFFF) begin
              state  <= RD;
              Mem_Rd <= 1'b1;
            end else begin
              state     <= WR;
              Mem_Wr    <= 1'b1;
              Mem_WData <= shifted;
            end
`endif
          end
        end
        RD: begin
          if (Mem_Ack) begin
            lat_rdata <= Mem_RData;
            Mem_Rd    <= 1'b0;
            state     <= MERGE;
          end else if (timed_out) begin
            Mem_Rd <= 1'b0;
            Err    <= 1'b1;
            state  <= ERR;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        MERGE: begin
          Mem_WData <= merged;
          Mem_Wr    <= 1'b1;
          wait_cnt  <= '0;
          state     <= WR;
        end
        WR: begin
          if (Mem_Ack || timed_out) begin
            Mem_Wr <= 1'b0;
`ifdef STORE_BYTE_EN_PORT_EN
            Mem_BE <= '0;
`endif
            Done   <= Mem_Ack;
            Err    <= !Mem_Ack;
            state  <= Mem_Ack ? DONE : ERR;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: begin
          state     <= IDLE;
          Req_Ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// tb/tb_store_rmw_ctrl.sv - directed self-checking bench for store_rmw_ctrl
module tb_store_rmw_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic [31:0] Req_Addr = '0;
  logic [31:0] Req_Data = '0;
  logic [1:0]  Req_Size = '0;
  logic [31:0] Mem_Addr;
  logic        Mem_Rd;
  logic        Mem_Wr;
  logic [31:0] Mem_WData;
  logic [31:0] Mem_RData = '0;
  logic        Mem_Ack = 1'b0;
  logic        Done;
  logic        Err;
`ifdef STORE_BYTE_EN_PORT_EN
  logic [3:0]  Mem_BE;
`endif

  int checks = 0;
  int errors = 0;

  int          cyc, done_cyc, err_cyc, ready_cyc, done_cnt, err_cnt;
  int          rd_cycles, wr_cycles;
  bit          both_seen;
  logic [31:0] wdata_seen, addr_seen;

  store_rmw_ctrl #(.ADDR_W(32), .ACK_TIMEOUT(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Req_Valid (Req_Valid),
    .Req_Ready (Req_Ready),
    .Req_Addr  (Req_Addr),
    .Req_Data  (Req_Data),
    .Req_Size  (Req_Size),
    .Mem_Addr  (Mem_Addr),
    .Mem_Rd    (Mem_Rd),
    .Mem_Wr    (Mem_Wr),
    .Mem_WData (Mem_WData),
    .Mem_RData (Mem_RData),
    .Mem_Ack   (Mem_Ack),
`ifdef STORE_BYTE_EN_PORT_EN
    .Mem_BE    (Mem_BE),
`endif
    .Done      (Done),
    .Err       (Err)
  );

  always #5 CLK = ~CLK;

  // Cycle 1 is the accept cycle; the memory acks after rd_delay/wr_delay wait cycles.
  task automatic run_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                           input logic [31:0] word, input int rd_delay, input int wr_delay,
                           input bit ack_on);
    int rd_wait = 0;
    int wr_wait = 0;
    done_cyc = 0; err_cyc = 0; ready_cyc = 0; done_cnt = 0; err_cnt = 0;
    rd_cycles = 0; wr_cycles = 0; both_seen = 0; wdata_seen = '0; addr_seen = '0;
    Mem_RData = word;
    @(negedge CLK);
    Req_Addr = addr; Req_Data = data; Req_Size = size; Req_Valid = 1'b1;
    @(negedge CLK);
    Req_Valid = 1'b0;
    cyc = 2;
    for (int i = 0; i < 12; i++) begin
      Mem_Ack = 1'b0;
      if (Mem_Rd && Mem_Wr) both_seen = 1;
      if (Mem_Rd) begin
        rd_cycles++; addr_seen = Mem_Addr;
        if (ack_on && rd_wait == rd_delay) Mem_Ack = 1'b1;
        rd_wait++;
      end else if (Mem_Wr) begin
        wr_cycles++; addr_seen = Mem_Addr; wdata_seen = Mem_WData;
        if (ack_on && wr_wait == wr_delay) Mem_Ack = 1'b1;
        wr_wait++;
      end
      if (Done) begin done_cnt++; done_cyc = cyc; end
      if (Err) begin err_cnt++; err_cyc = cyc; end
      if (Req_Ready && ready_cyc == 0) ready_cyc = cyc;
      @(negedge CLK);
      cyc++;
    end
    Mem_Ack = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++; if (Req_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", Req_Ready); end
    checks++; if ({Mem_Rd, Mem_Wr, Done, Err} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {Mem_Rd, Mem_Wr, Done, Err}); end
    checks++; if (Mem_Addr !== 32'h0 || Mem_WData !== 32'h0) begin errors++; $display("FAIL reset_bus: got addr=%h wdata=%h expected 0/0", Mem_Addr, Mem_WData); end
    RST = 1'b0;
  endtask

  task automatic test_sb;
    run_store(32'h102, 32'hAB, 2'b00, 32'h11223344, 0, 0, 1'b1);
    checks++; if (wdata_seen !== 32'h11AB3344) begin errors++; $display("FAIL sb_wdata: got %h expected 11ab3344", wdata_seen); end
    checks++; if (addr_seen !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h expected 00000100", addr_seen); end
    checks++; if (rd_cycles !== 1 || wr_cycles !== 1) begin errors++; $display("FAIL sb_strobes: got rd=%0d wr=%0d expected 1/1", rd_cycles, wr_cycles); end
    checks++; if (done_cyc !== 5 || done_cnt !== 1) begin errors++; $display("FAIL sb_latency: got cycle %0d count %0d expected 5/1", done_cyc, done_cnt); end
    checks++; if (both_seen) begin errors++; $display("FAIL sb_exclusive: got rd&wr=1 expected 0"); end
  endtask

  task automatic test_sh_delayed;
    run_store(32'h206, 32'hBEEF, 2'b01, 32'hFFFFFFFF, 3, 0, 1'b1);
    checks++; if (wdata_seen !== 32'hBEEFFFFF) begin errors++; $display("FAIL sh_wdata: got %h expected beefffff", wdata_seen); end
    checks++; if (rd_cycles !== 4) begin errors++; $display("FAIL sh_rd_hold: got %0d expected 4", rd_cycles); end
    checks++; if (done_cnt !== 1 || err_cnt !== 0 || done_cyc !== 8) begin errors++; $display("FAIL sh_done: got count %0d err %0d cycle %0d expected 1/0/8", done_cnt, err_cnt, done_cyc); end
  endtask

  task automatic test_sb_lane3_wr_wait;
    run_store(32'h7, 32'h5A, 2'b00, 32'h0, 0, 2, 1'b1);
    checks++; if (wdata_seen !== 32'h5A000000 || addr_seen !== 32'h4) begin errors++; $display("FAIL sb3_wdata: got %h @%h expected 5a000000 @00000004", wdata_seen, addr_seen); end
    checks++; if (done_cyc !== 7 || wr_cycles !== 3) begin errors++; $display("FAIL sb3_latency: got cycle %0d wr %0d expected 7/3", done_cyc, wr_cycles); end
  endtask

  task automatic test_sw;
    run_store(32'h300, 32'hCAFEF00D, 2'b10, 32'h0, 0, 0, 1'b1);
    checks++; if (rd_cycles !== 0) begin errors++; $display("FAIL sw_no_read: got %0d expected 0", rd_cycles); end
    checks++; if (wdata_seen !== 32'hCAFEF00D || addr_seen !== 32'h300) begin errors++; $display("FAIL sw_wdata: got %h @%h expected cafef00d @00000300", wdata_seen, addr_seen); end
    checks++; if (done_cyc !== 3 || done_cnt !== 1) begin errors++; $display("FAIL sw_latency: got cycle %0d count %0d expected 3/1", done_cyc, done_cnt); end
  endtask

  task automatic test_reject;
    logic [31:0] addrs [3];
    logic [1:0]  sizes [3];
    addrs = '{32'h101, 32'h102, 32'h100};
    sizes = '{2'b01, 2'b10, 2'b11};
    for (int k = 0; k < 3; k++) begin
      run_store(addrs[k], 32'h1234, sizes[k], 32'h0, 0, 0, 1'b1);
      checks++; if (err_cnt !== 1 || err_cyc !== 2 || done_cnt !== 0) begin errors++; $display("FAIL reject_%0d_err: got count %0d cycle %0d done %0d expected 1/2/0", k, err_cnt, err_cyc, done_cnt); end
      checks++; if (rd_cycles !== 0 || wr_cycles !== 0) begin errors++; $display("FAIL reject_%0d_strobe: got rd=%0d wr=%0d expected 0/0", k, rd_cycles, wr_cycles); end
      checks++; if (ready_cyc !== 3) begin errors++; $display("FAIL reject_%0d_ready: got cycle %0d expected 3", k, ready_cyc); end
    end
  endtask

  task automatic test_timeout;
    run_store(32'h10, 32'h77, 2'b00, 32'h0, 0, 0, 1'b0);
    checks++; if (rd_cycles !== 4 || wr_cycles !== 0) begin errors++; $display("FAIL timeout_strobes: got rd=%0d wr=%0d expected 4/0", rd_cycles, wr_cycles); end
    checks++; if (err_cnt !== 1 || err_cyc !== 6 || done_cnt !== 0) begin errors++; $display("FAIL timeout_err: got count %0d cycle %0d done %0d expected 1/6/0", err_cnt, err_cyc, done_cnt); end
  endtask

  task automatic test_reset_mid_wr;
    int stray = 0;
    Mem_RData = 32'h0;
    @(negedge CLK);
    Req_Addr = 32'h102; Req_Data = 32'hAB; Req_Size = 2'b00; Req_Valid = 1'b1;
    @(negedge CLK);
    Req_Valid = 1'b0;
    Mem_Ack = Mem_Rd;
    @(negedge CLK);
    Mem_Ack = 1'b0;
    @(negedge CLK);
    checks++; if (Mem_Wr !== 1'b1) begin errors++; $display("FAIL rst_pre_wr: got %b expected 1", Mem_Wr); end
    #1 RST = 1'b1;
    #1;
    checks++; if (Mem_Wr !== 1'b0 || Req_Ready !== 1'b1 || Done !== 1'b0 || Err !== 1'b0) begin errors++; $display("FAIL rst_mid_wr: got wr=%b ready=%b done=%b err=%b expected 0/1/0/0", Mem_Wr, Req_Ready, Done, Err); end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (Done || Err || Mem_Wr || Mem_Rd) stray++;
      @(negedge CLK);
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_quiet: got %0d active cycles expected 0", stray); end
    run_store(32'h400, 32'h12345678, 2'b10, 32'h0, 0, 0, 1'b1);
    checks++; if (done_cyc !== 3 || wdata_seen !== 32'h12345678) begin errors++; $display("FAIL rst_then_sw: got cycle %0d wdata %h expected 3/12345678", done_cyc, wdata_seen); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh_delayed();
    test_sb_lane3_wr_wait();
    test_sw();
    test_reject();
    test_timeout();
    test_reset_mid_wr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
